// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and helpers for the TPU input path
package tpu_pkg;

  localparam int DATA_W  = 16;
  localparam int ARRAY_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  // Column count is forced into 1..max_w so at least one lane is always live.
  function automatic logic [15:0] clamp_cols(input logic [15:0] cols, input int max_w);
    if (cols == 16'd0) begin
      return 16'd1;
    end
    if (cols > 16'(max_w)) begin
      return 16'(max_w);
    end
    return cols;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - per-lane shift register, DEPTH=0 collapses to a wire
module skew_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_data       = in_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [DEPTH];
      logic [WIDTH-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign out_data = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - west-side input stage of the 2x2 systolic array
module systolic_feeder #(
  parameter int DATA_W  = tpu_pkg::DATA_W,
  parameter int ARRAY_W = tpu_pkg::ARRAY_W,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_num_rows,
  input  logic [15:0]       cfg_num_cols,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  output logic [DATA_W-1:0] sys_data_in_1x,
  output logic [DATA_W-1:0] sys_data_in_2x,
  output logic              sys_start,
  output logic              sys_start_2,
  output logic [15:0]       ub_rd_col_size_out,
  output logic              ub_rd_col_size_valid_out,
  output logic              busy,
  output logic              done
);
  import tpu_pkg::*;

  localparam int LANE_W = DATA_W + 1;
  localparam int DRN_W  = $clog2(ARRAY_W + 1);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  rows_left_q, rows_left_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [15:0]       cols_q, cols_d;
  logic              col_size_valid_q, col_size_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LANE_W-1:0] stage_q [ARRAY_W];
  logic [LANE_W-1:0] stage_d [ARRAY_W];
  logic [LANE_W-1:0] lane_out [ARRAY_W];
  logic [DATA_W-1:0] lane_in [ARRAY_W];
  logic              accept;

  assign lane_in[0] = in_data_0;
  assign lane_in[1] = in_data_1;

  assign in_ready = (state_q == STREAM) && (rows_left_q != '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d          = state_q;
    rows_left_d      = rows_left_q;
    drain_d          = drain_q;
    cols_d           = cols_q;
    col_size_valid_d = 1'b0;
    done_d           = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          rows_left_d      = cfg_num_rows;
          cols_d           = clamp_cols(cfg_num_cols, ARRAY_W);
          col_size_valid_d = 1'b1;
          state_d          = CFG;
        end
      end
      CFG: begin
        if (rows_left_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          rows_left_d = rows_left_q - CNT_W'(1);
          if (rows_left_q == CNT_W'(1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Hold until the deepest skew lane has emitted the final beat.
        if (drain_q == DRN_W'(ARRAY_W - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // A bubble enters every lane as valid=0, data=0; disabled lanes keep their valid.
    for (int i = 0; i < ARRAY_W; i++) begin
      stage_d[i] = {accept, (accept && (16'(i) < cols_q)) ? lane_in[i] : '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      rows_left_q      <= '0;
      drain_q          <= '0;
      cols_q           <= '0;
      col_size_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      for (int i = 0; i < ARRAY_W; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      rows_left_q      <= rows_left_d;
      drain_q          <= drain_d;
      cols_q           <= cols_d;
      col_size_valid_q <= col_size_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      for (int i = 0; i < ARRAY_W; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < ARRAY_W; g++) begin : g_lane
      skew_delay_line #(
        .WIDTH(LANE_W),
        .DEPTH(g)
      ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .in_data (stage_q[g]),
        .out_data(lane_out[g])
      );
    end
  endgenerate

  assign sys_data_in_1x           = lane_out[0][DATA_W-1:0];
  assign sys_start                = lane_out[0][DATA_W];
  assign sys_data_in_2x           = lane_out[1][DATA_W-1:0];
  assign sys_start_2              = lane_out[1][DATA_W];
  assign ub_rd_col_size_out       = cols_q;
  assign ub_rd_col_size_valid_out = col_size_valid_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized job-level bench for systolic_feeder
module tb_systolic_feeder;

  localparam int DATA_W  = 16;
  localparam int ARRAY_W = 2;
  localparam int CNT_W   = 16;
  localparam int MAXT    = 96;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_num_rows;
  logic [15:0]       cfg_num_cols;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data_0;
  logic [DATA_W-1:0] in_data_1;
  logic [DATA_W-1:0] sys_data_in_1x;
  logic [DATA_W-1:0] sys_data_in_2x;
  logic              sys_start;
  logic              sys_start_2;
  logic [15:0]       ub_rd_col_size_out;
  logic              ub_rd_col_size_valid_out;
  logic              busy;
  logic              done;

  systolic_feeder #(
    .DATA_W (DATA_W),
    .ARRAY_W(ARRAY_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_start               (cfg_start),
    .cfg_num_rows            (cfg_num_rows),
    .cfg_num_cols            (cfg_num_cols),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_data_0               (in_data_0),
    .in_data_1               (in_data_1),
    .sys_data_in_1x          (sys_data_in_1x),
    .sys_data_in_2x          (sys_data_in_2x),
    .sys_start               (sys_start),
    .sys_start_2             (sys_start_2),
    .ub_rd_col_size_out      (ub_rd_col_size_out),
    .ub_rd_col_size_valid_out(ub_rd_col_size_valid_out),
    .busy                    (busy),
    .done                    (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic              tr_s1   [MAXT];
  logic              tr_s2   [MAXT];
  logic              tr_done [MAXT];
  logic [DATA_W-1:0] tr_d1   [MAXT];
  logic [DATA_W-1:0] tr_d2   [MAXT];
  logic [15:0]       tr_cols;
  int                last_t;

  // One job from cfg_start to the first IDLE cycle after done. Index t counts
  // rising edges after the cfg_start edge; outputs are sampled at the falling edge.
  task automatic run_job(input int rows, input int cols, input int vmode,
                         input logic [7:0] vpat, input bit seq_data,
                         input int repulse_t, input string name);
    logic              es1 [MAXT+4];
    logic              es2 [MAXT+4];
    logic [DATA_W-1:0] ed1 [MAXT+4];
    logic [DATA_W-1:0] ed2 [MAXT+4];
    logic [53:0]       obs;
    logic [53:0]       expv;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              v;
    logic              rdy;
    int                acc;
    int                done_t;
    int                ccl;
    acc    = 0;
    last_t = -1;
    ccl    = (cols == 0) ? 1 : ((cols > ARRAY_W) ? ARRAY_W : cols);
    done_t = (rows == 0) ? 2 : -1;
    for (int i = 0; i < MAXT + 4; i++) begin
      es1[i] = 1'b0; es2[i] = 1'b0; ed1[i] = '0; ed2[i] = '0;
    end
    for (int i = 0; i < MAXT; i++) begin
      tr_s1[i] = 1'b0; tr_s2[i] = 1'b0; tr_done[i] = 1'b0; tr_d1[i] = '0; tr_d2[i] = '0;
    end
    @(negedge clk);
    cfg_start    = 1'b1;
    cfg_num_rows = CNT_W'(rows);
    cfg_num_cols = 16'(cols);
    in_valid     = 1'($urandom_range(0, 1));
    in_data_0    = DATA_W'($urandom);
    in_data_1    = DATA_W'($urandom);
    for (int t = 1; t < MAXT; t++) begin
      @(negedge clk);
      rdy  = (t >= 2) && (acc < rows);
      expv = {rdy, es1[t], ed1[t], es2[t], ed2[t], 1'(t == 1),
              (t == 1) ? 16'(ccl) : 16'h0,
              1'((done_t < 0) || (t <= done_t)), 1'(t == done_t)};
      obs  = {in_ready, sys_start, sys_data_in_1x, sys_start_2, sys_data_in_2x,
              ub_rd_col_size_valid_out, (t == 1) ? ub_rd_col_size_out : 16'h0, busy, done};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s t=%0d got=%h want=%h", name, t, obs, expv);
      end
      tr_s1[t] = sys_start; tr_s2[t] = sys_start_2; tr_done[t] = done;
      tr_d1[t] = sys_data_in_1x; tr_d2[t] = sys_data_in_2x;
      if (t == 1) tr_cols = ub_rd_col_size_out;
      if (done_t >= 0 && t == done_t + 1) begin
        last_t = t;
        break;
      end
      cfg_start    = (t == repulse_t);
      cfg_num_rows = (t == repulse_t) ? CNT_W'(9) : CNT_W'(rows);
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = ($urandom_range(0, 3) != 0);
      else                 v = (t >= 2 && t - 2 < 8) ? vpat[3'(t - 2)] : 1'b0;
      a = seq_data ? DATA_W'(2 * acc + 1) : DATA_W'($urandom);
      b = seq_data ? DATA_W'(2 * acc + 2) : DATA_W'($urandom);
      in_valid  = v;
      in_data_0 = a;
      in_data_1 = b;
      if (rdy && v) begin
        es1[t+1] = 1'b1; ed1[t+1] = a;
        es2[t+2] = 1'b1; ed2[t+2] = (ccl >= 2) ? b : '0;
        acc++;
        if (acc == rows) done_t = t + 1 + ARRAY_W;
      end
    end
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    checks++;
    if (!(done_t >= 0 && last_t == done_t + 1)) begin
      errors++;
      $display("FAIL %s_timeout last_t=%0d want_done_t=%0d", name, last_t, done_t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, sys_start, sys_start_2, sys_data_in_1x, sys_data_in_2x,
         ub_rd_col_size_out, ub_rd_col_size_valid_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got_busy=%b got_start=%b got_col=%h want=0",
               busy, sys_start, ub_rd_col_size_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int ndone;
    run_job(3, 2, 0, 8'h00, 1'b1, -1, "basic");
    checks++;
    if ({tr_d1[3], tr_d1[4], tr_d1[5]} !== {16'd1, 16'd3, 16'd5}) begin
      errors++;
      $display("FAIL basic_lane0 got=%0d,%0d,%0d want=1,3,5", tr_d1[3], tr_d1[4], tr_d1[5]);
    end
    checks++;
    if ({tr_d2[4], tr_d2[5], tr_d2[6]} !== {16'd2, 16'd4, 16'd6}) begin
      errors++;
      $display("FAIL basic_lane1 got=%0d,%0d,%0d want=2,4,6", tr_d2[4], tr_d2[5], tr_d2[6]);
    end
    checks++;
    if (tr_cols !== 16'd2) begin
      errors++;
      $display("FAIL basic_colsize got=%0d want=2", tr_cols);
    end
    ndone = 0;
    for (int t = 1; t <= last_t && t < MAXT; t++) ndone += int'(tr_done[t]);
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL basic_done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_bubble();
    run_job(2, 2, 2, 8'b0000_0101, 1'b1, -1, "bubble");
    checks++;
    if ({tr_s1[3], tr_s1[4], tr_s1[5], tr_d1[3], tr_d1[4], tr_d1[5]} !==
        {3'b101, 16'd1, 16'd0, 16'd3}) begin
      errors++;
      $display("FAIL bubble_lane0 got=%b%b%b %0d,%0d,%0d want=101 1,0,3",
               tr_s1[3], tr_s1[4], tr_s1[5], tr_d1[3], tr_d1[4], tr_d1[5]);
    end
    checks++;
    if ({tr_s2[4], tr_s2[5], tr_s2[6], tr_d2[4], tr_d2[5], tr_d2[6]} !==
        {3'b101, 16'd2, 16'd0, 16'd4}) begin
      errors++;
      $display("FAIL bubble_lane1 got=%b%b%b %0d,%0d,%0d want=101 2,0,4",
               tr_s2[4], tr_s2[5], tr_s2[6], tr_d2[4], tr_d2[5], tr_d2[6]);
    end
  endtask

  task automatic test_zero_rows();
    run_job(0, 2, 1, 8'h00, 1'b0, -1, "zero_rows");
    checks++;
    if (tr_done[2] !== 1'b1) begin
      errors++;
      $display("FAIL zero_rows_done got=%b want=1", tr_done[2]);
    end
  endtask

  task automatic test_clamp();
    int n2;
    int nz;
    run_job(2, 5, 1, 8'h00, 1'b0, -1, "clamp_hi");
    checks++;
    if (tr_cols !== 16'd2) begin
      errors++;
      $display("FAIL clamp_hi_colsize got=%0d want=2", tr_cols);
    end
    run_job(3, 0, 1, 8'h00, 1'b0, -1, "clamp_zero");
    checks++;
    if (tr_cols !== 16'd1) begin
      errors++;
      $display("FAIL clamp_zero_colsize got=%0d want=1", tr_cols);
    end
    run_job(3, 1, 0, 8'h00, 1'b0, -1, "one_col");
    n2 = 0;
    nz = 0;
    for (int t = 1; t <= last_t && t < MAXT; t++) begin
      n2 += int'(tr_s2[t]);
      if (tr_d2[t] != '0) nz++;
    end
    checks++;
    if (n2 != 3 || nz != 0) begin
      errors++;
      $display("FAIL one_col_lane1 got_valid=%0d got_nonzero=%0d want=3,0", n2, nz);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cfg_start    = 1'b1;
    cfg_num_rows = CNT_W'(4);
    cfg_num_cols = 16'd2;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_0 = 16'hAAAA;
    in_data_1 = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({sys_start, sys_data_in_1x, busy} !== {1'b1, 16'hAAAA, 1'b1}) begin
      errors++;
      $display("FAIL midrst_beat got=%b %h %b want=1 aaaa 1", sys_start, sys_data_in_1x, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, sys_start, sys_start_2, sys_data_in_1x, sys_data_in_2x,
         ub_rd_col_size_out, ub_rd_col_size_valid_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got_start=%b got_2x=%h got_busy=%b want=0",
               sys_start, sys_data_in_2x, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cyc=%0d got_done=%b got_busy=%b want=0,0", i, done, busy);
      end
    end
    run_job(4, 2, 1, 8'h00, 1'b0, -1, "after_rst");
  endtask

  task automatic test_repulse();
    int n1;
    run_job(4, 2, 1, 8'h00, 1'b0, 4, "repulse");
    n1 = 0;
    for (int t = 1; t <= last_t && t < MAXT; t++) n1 += int'(tr_s1[t]);
    checks++;
    if (n1 != 4) begin
      errors++;
      $display("FAIL repulse_beats got=%0d want=4", n1);
    end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 12), $urandom_range(0, 4), 1, 8'h00, 1'b0, -1, "random");
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cfg_num_rows = '0;
    cfg_num_cols = '0;
    in_valid     = 1'b0;
    in_data_0    = '0;
    in_data_1    = '0;
    test_reset();
    test_basic();
    test_bubble();
    test_zero_rows();
    test_clamp();
    test_reset_mid();
    test_repulse();
    test_random_jobs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
